// File: rtl/rom_load_pkg.sv
// Shared types and the ROM region map for the Pacman Plus ROM download controller.
// Region limits are inclusive byte addresses within the linear download image.
package rom_load_pkg;

    typedef enum logic [2:0] {
        PROG0    = 3'd0,
        GFX_CHR  = 3'd1,
        GFX_SPR  = 3'd2,
        PROG1    = 3'd3,
        PAL_PROM = 3'd4,
        LUT_PROM = 3'd5,
        SND_PROM = 3'd6,
        REG_NONE = 3'd7
    } rom_region_t;

    localparam int NUM_REGIONS = 7;

    // Indexed by the rom_region_t value of each region.
    localparam logic [15:0] REGION_BASE [NUM_REGIONS] = '{
        16'h0000, 16'h4000, 16'h5000, 16'h8000, 16'hC000, 16'hC020, 16'hC120
    };
    localparam logic [15:0] REGION_LAST [NUM_REGIONS] = '{
        16'h3FFF, 16'h4FFF, 16'h5FFF, 16'hBFFF, 16'hC01F, 16'hC11F, 16'hC2FF
    };

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_CHECK = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_RUN   = 3'd4;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational decode of a linear download address into region select and region-local address.
// Addresses falling in gaps between regions (or above 16 bits) decode as REG_NONE with valid low.
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic [24:0]   addr,
    output rom_region_t   region,
    output logic [AW-1:0] local_addr,
    output logic          valid
);

    // 17-bit difference: bit 16 flags an address below the region base.
    logic [16:0]            diff [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            assign diff[gi] = {1'b0, addr[15:0]} - {1'b0, REGION_BASE[gi]};
            assign hit[gi]  = (addr[24:16] == 9'd0) && !diff[gi][16] &&
                              (diff[gi][15:0] <= (REGION_LAST[gi] - REGION_BASE[gi]));
        end
    endgenerate

    always_comb begin
        region     = REG_NONE;
        local_addr = '0;
        valid      = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (hit[i]) begin
                region     = rom_region_t'(i[2:0]);
                local_addr = AW'(diff[i][15:0]);
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_load_ctrl.sv
// Sequences the HPS ROM download into core ROM regions and holds the core in reset
// until a complete, in-range image has loaded plus a settling period.
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter logic [15:0] IMG_SIZE = 16'hC300,
    parameter int          HOLD_CYC = 1024,
    parameter int          AW       = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic [AW-1:0] dn_addr,
    output logic [7:0]    dn_data,
    output logic          dn_wr,
    output logic [2:0]    dn_region,
    output logic          core_reset,
    output logic          load_ok,
    output logic          load_err,
    output logic [15:0]   byte_cnt
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);

    state_t        state_reg, state_next;
    logic          dl_reg;
    logic [15:0]   hold_cnt_reg;
    logic [15:0]   byte_cnt_reg;
    logic          overflow_reg, load_ok_reg, load_err_reg, dn_wr_reg;
    logic [AW-1:0] dn_addr_reg;
    logic [7:0]    dn_data_reg;
    logic [2:0]    dn_region_reg;

    rom_region_t   dec_region;
    logic [AW-1:0] dec_addr;
    logic          dec_valid;

    logic rise, fall, in_window, in_range, accept, bad_wr, image_ok;

    rom_region_decode #(.AW(AW)) u_decode (
        .addr       (ioctl_addr),
        .region     (dec_region),
        .local_addr (dec_addr),
        .valid      (dec_valid)
    );

    // Tracks the window even through RESET so a still-open window is not seen as a new download.
    always_ff @(posedge CLK) dl_reg <= ioctl_download;

    assign rise      = ioctl_download & ~dl_reg;
    assign fall      = ~ioctl_download & dl_reg;
    assign in_window = (state_reg == ST_LOAD) | rise;
    assign in_range  = (ioctl_addr[24:16] == 9'd0) && (ioctl_addr[15:0] < IMG_SIZE);
    assign accept    = in_window & ioctl_wr & in_range;
    assign bad_wr    = in_window & ioctl_wr & ~in_range;
    assign image_ok  = (byte_cnt_reg == IMG_SIZE) && !overflow_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  state_next = ST_IDLE;
            ST_LOAD:  if (fall) state_next = ST_CHECK;
            ST_CHECK: state_next = image_ok ? ST_HOLD : ST_IDLE;
            ST_HOLD:  if (hold_cnt_reg == HOLD_LAST) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase
        if (rise) state_next = ST_LOAD;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            hold_cnt_reg  <= '0;
            byte_cnt_reg  <= '0;
            overflow_reg  <= 1'b0;
            load_ok_reg   <= 1'b0;
            load_err_reg  <= 1'b0;
            dn_wr_reg     <= 1'b0;
            dn_addr_reg   <= '0;
            dn_data_reg   <= '0;
            dn_region_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= (state_reg == ST_HOLD) ? hold_cnt_reg + 16'd1 : 16'd0;

            // A write in the edge cycle belongs to the new download, so it lands after the clear.
            if (rise) begin
                byte_cnt_reg <= accept ? 16'd1 : 16'd0;
                overflow_reg <= bad_wr;
                load_ok_reg  <= 1'b0;
                load_err_reg <= 1'b0;
            end else begin
                if (accept && byte_cnt_reg != 16'hFFFF) byte_cnt_reg <= byte_cnt_reg + 16'd1;
                if (bad_wr) overflow_reg <= 1'b1;
                if (state_reg == ST_CHECK) begin
                    load_ok_reg  <= image_ok;
                    load_err_reg <= !image_ok;
                end
            end

            dn_wr_reg <= accept & dec_valid;
            if (accept && dec_valid) begin
                dn_addr_reg   <= dec_addr;
                dn_data_reg   <= ioctl_dout;
                dn_region_reg <= dec_region;
            end
        end
    end

    assign core_reset = (state_reg != ST_RUN) | rise;
    assign dn_addr    = dn_addr_reg;
    assign dn_data    = dn_data_reg;
    assign dn_wr      = dn_wr_reg;
    assign dn_region  = dn_region_reg;
    assign load_ok    = load_ok_reg;
    assign load_err   = load_err_reg;
    assign byte_cnt   = byte_cnt_reg;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl: region mapping, overflow, short/full images, hold timing.
// A second tiny-image instance shares the stimulus so a download edge can be placed inside HOLD.
module tb_rom_load_ctrl;
    import rom_load_pkg::*;

    localparam int HOLD = 40;
    localparam int S_HOLD = 8;

    logic        CLK, RESET;
    logic        ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [15:0] dn_addr, byte_cnt;
    logic [7:0]  dn_data;
    logic        dn_wr, core_reset, load_ok, load_err;
    logic [2:0]  dn_region;

    logic [15:0] s_dn_addr, s_byte_cnt;
    logic [7:0]  s_dn_data;
    logic        s_dn_wr, s_core_reset, s_load_ok, s_load_err;
    logic [2:0]  s_dn_region;

    int n_cmp = 0;
    int n_bad = 0;

    rom_load_ctrl #(.IMG_SIZE(16'hC300), .HOLD_CYC(HOLD), .AW(16)) dut (
        .CLK(CLK), .RESET(RESET), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .dn_addr(dn_addr), .dn_data(dn_data),
        .dn_wr(dn_wr), .dn_region(dn_region), .core_reset(core_reset), .load_ok(load_ok),
        .load_err(load_err), .byte_cnt(byte_cnt)
    );

    rom_load_ctrl #(.IMG_SIZE(16'h0004), .HOLD_CYC(S_HOLD), .AW(16)) dut_small (
        .CLK(CLK), .RESET(RESET), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .dn_addr(s_dn_addr), .dn_data(s_dn_data),
        .dn_wr(s_dn_wr), .dn_region(s_dn_region), .core_reset(s_core_reset), .load_ok(s_load_ok),
        .load_err(s_load_err), .byte_cnt(s_byte_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
    endtask

    task automatic dwrite(input logic [24:0] a, input logic [7:0] d);
        do_write(a, d);
        $display("wr addr=0x%07h data=0x%02h -> dn_wr=%0d region=%0d dn_addr=0x%04h byte_cnt=0x%04h",
                 a, d, dn_wr, dn_region, dn_addr, byte_cnt);
    endtask

    initial begin
        int n;
        RESET = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        step(); step();
        check_eq("rst_dn_wr", dn_wr, 0);
        check_eq("rst_dn_addr", dn_addr, 0);
        check_eq("rst_dn_data", dn_data, 0);
        check_eq("rst_dn_region", dn_region, 0);
        check_eq("rst_byte_cnt", byte_cnt, 0);
        check_eq("rst_core_reset", core_reset, 1);
        check_eq("rst_load_ok", load_ok, 0);
        check_eq("rst_load_err", load_err, 0);
        RESET = 1'b0;
        step();

        // Region mapping; the first write coincides with the rising edge.
        ioctl_download = 1'b1;
        dwrite(25'h0005010, 8'hA5);
        check_eq("spr_wr", dn_wr, 1);
        check_eq("spr_region", dn_region, GFX_SPR);
        check_eq("spr_addr", dn_addr, 16'h0010);
        check_eq("spr_data", dn_data, 8'hA5);
        dwrite(25'h000C125, 8'h3C);
        check_eq("snd_region", dn_region, SND_PROM);
        check_eq("snd_addr", dn_addr, 16'h0005);
        check_eq("snd_data", dn_data, 8'h3C);
        step();
        check_eq("idle_wr", dn_wr, 0);
        check_eq("idle_hold_addr", dn_addr, 16'h0005);
        dwrite(25'h0006000, 8'h11);
        check_eq("gap_wr", dn_wr, 0);
        check_eq("gap_cnt", byte_cnt, 3);
        for (int i = 0; i < 4; i++) begin
            dwrite(25'h0004000 + 25'(i), 8'(8'h80 + i));
            check_eq("b2b_wr", dn_wr, 1);
            check_eq("b2b_region", dn_region, GFX_CHR);
            check_eq("b2b_addr", dn_addr, 32'(i));
        end
        dwrite(25'h0008123, 8'h5A);
        check_eq("prog1_region", dn_region, PROG1);
        check_eq("prog1_addr", dn_addr, 16'h0123);
        dwrite(25'h000C020, 8'h77);
        check_eq("lut_region", dn_region, LUT_PROM);
        check_eq("lut_addr", dn_addr, 16'h0000);
        dwrite(25'h0000000, 8'h01);
        check_eq("prog0_region", dn_region, PROG0);
        ioctl_download = 1'b0;
        dwrite(25'h0000001, 8'hEE);
        check_eq("fall_wr", dn_wr, 1);
        check_eq("fall_addr", dn_addr, 16'h0001);
        check_eq("fall_cnt", byte_cnt, 11);
        step();
        check_eq("partial_err", load_err, 1);
        check_eq("partial_ok", load_ok, 0);
        check_eq("partial_core_reset", core_reset, 1);

        // Out-of-range writes.
        ioctl_download = 1'b1;
        step();
        check_eq("ovf_err_cleared", load_err, 0);
        dwrite(25'h000C300, 8'hAA);
        check_eq("ovf_c300_wr", dn_wr, 0);
        dwrite(25'h0010000, 8'hBB);
        check_eq("ovf_10000_wr", dn_wr, 0);
        check_eq("ovf_cnt", byte_cnt, 0);
        ioctl_download = 1'b0;
        step(); step();
        check_eq("ovf_err", load_err, 1);
        check_eq("ovf_ok", load_ok, 0);
        step(); step(); step();
        check_eq("ovf_core_reset", core_reset, 1);

        // Tiny image on the small instance, then a new download edge during its HOLD.
        ioctl_download = 1'b1;
        for (int i = 0; i < 4; i++) dwrite(25'(i), 8'(i));
        ioctl_download = 1'b0;
        step(); step();
        check_eq("small_ok", s_load_ok, 1);
        check_eq("small_cnt", s_byte_cnt, 4);
        check_eq("main_short4_err", load_err, 1);
        step(); step(); step();
        check_eq("small_hold_core_reset", s_core_reset, 1);
        ioctl_download = 1'b1;
        #1;
        check_eq("small_edge_core_reset", s_core_reset, 1);
        step();
        check_eq("small_edge_cnt", s_byte_cnt, 0);
        check_eq("small_edge_ok", s_load_ok, 0);
        for (int i = 0; i < 20; i++) step();
        check_eq("small_load_core_reset", s_core_reset, 1);

        // RESET in LOAD beats a concurrent write and aborts to IDLE.
        dwrite(25'h0000010, 8'h10);
        check_eq("pre_rst_cnt", byte_cnt, 1);
        RESET = 1'b1;
        ioctl_addr = 25'h0000011; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
        step();
        ioctl_wr = 1'b0; RESET = 1'b0;
        check_eq("abort_dn_wr", dn_wr, 0);
        check_eq("abort_cnt", byte_cnt, 0);
        check_eq("abort_ok", load_ok, 0);
        check_eq("abort_err", load_err, 0);
        check_eq("abort_core_reset", core_reset, 1);
        step(); step();
        dwrite(25'h0000012, 8'h12);
        check_eq("idle_ignore_wr", dn_wr, 0);
        check_eq("idle_ignore_cnt", byte_cnt, 0);
        ioctl_download = 1'b0;
        step(); step();
        check_eq("idle_no_check", load_err, 0);

        // Short image.
        ioctl_download = 1'b1;
        for (int a = 0; a < 16'h2000; a++) do_write(25'(a), 8'(a));
        ioctl_download = 1'b0;
        step(); step();
        $display("short download: byte_cnt=0x%04h load_ok=%0d load_err=%0d", byte_cnt, load_ok, load_err);
        check_eq("short_cnt", byte_cnt, 16'h2000);
        check_eq("short_err", load_err, 1);
        check_eq("short_ok", load_ok, 0);
        check_eq("short_core_reset", core_reset, 1);

        // Full image; last byte coincides with the falling edge.
        ioctl_download = 1'b1;
        for (int a = 0; a < 16'hC2FF; a++) do_write(25'(a), 8'(a));
        ioctl_download = 1'b0;
        do_write(25'h000C2FF, 8'h5C);
        $display("full download: byte_cnt=0x%04h dn_region=%0d dn_addr=0x%04h", byte_cnt, dn_region, dn_addr);
        check_eq("full_last_wr", dn_wr, 1);
        check_eq("full_last_region", dn_region, SND_PROM);
        check_eq("full_last_addr", dn_addr, 16'h01DF);
        check_eq("full_last_data", dn_data, 8'h5C);
        check_eq("full_cnt", byte_cnt, 16'hC300);
        step();
        n = 1;
        check_eq("full_ok", load_ok, 1);
        check_eq("full_err", load_err, 0);
        while (core_reset === 1'b1 && n < 200) begin
            step();
            n++;
        end
        $display("core_reset released %0d cycles after CHECK", n);
        check_eq("hold_release_cycles", n, HOLD + 1);

        // New download edge while running: reset reasserts immediately.
        ioctl_download = 1'b1;
        #1;
        check_eq("run_edge_core_reset", core_reset, 1);
        step();
        check_eq("run_edge_ok", load_ok, 0);
        check_eq("run_edge_cnt", byte_cnt, 0);
        check_eq("run_edge_core_reset2", core_reset, 1);
        ioctl_download = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
